// File: rtl/rom_ram_datapath_if.sv
// rom_ram_datapath_if: control strobes, readback and status bus of the ROM-to-RAM datapath
interface rom_ram_datapath_if #(parameter int DW = 8);
  logic          read_rom;
  logic          write_ram;
  logic [2:0]    rom_addr;
  logic [2:0]    ram_addr;
  logic          clr;
  logic [2:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] stage_data;
  logic          stage_valid;
  logic [3:0]    wr_count;
  logic [DW+2:0] checksum;
  logic          done;
  logic          err;
  modport master (
    output read_rom, write_ram, rom_addr, ram_addr, clr, rd_addr,
    input  rd_data, stage_data, stage_valid, wr_count, checksum, done, err
  );
  modport slave (
    input  read_rom, write_ram, rom_addr, ram_addr, clr, rd_addr,
    output rd_data, stage_data, stage_valid, wr_count, checksum, done, err
  );
endinterface

// File: rtl/rom_ram_datapath.sv
// rom_ram_datapath: ROM -> staging register -> offset adder -> RAM, with progress/checksum/error status
module rom_ram_datapath #(
  parameter int                DW       = 8,
  parameter logic [8*DW-1:0]   ROM_INIT = 64'h8070605040302010,
  parameter logic [DW-1:0]     OFFSET   = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  rom_ram_datapath_if.slave bus
);
  logic [DW-1:0] rom [8];
  logic [DW-1:0] ram_q [8];
  logic [DW-1:0] ram_d [8];
  logic [DW-1:0] stage_q, stage_d, rd_q, rd_d, wr_val;
  logic          valid_q, valid_d, err_q, err_d, wr_ok;
  logic [7:0]    mask_q, mask_d;
  logic [3:0]    count_q, count_d;
  logic [DW+2:0] sum_q, sum_d;
  // ROM is a pure combinational slice of the packed init constant
  always_comb
    for (int i = 0; i < 8; i++) rom[i] = ROM_INIT[i*DW +: DW];
  // next-state: a write consumes the pre-edge staging word; clr wipes status after the write is folded in
  always_comb begin
    wr_ok   = bus.write_ram & valid_q;
    wr_val  = stage_q + OFFSET;
    stage_d = bus.read_rom ? rom[bus.rom_addr] : stage_q;
    valid_d = bus.read_rom | (valid_q & ~bus.write_ram);
    ram_d   = ram_q;
    if (wr_ok) ram_d[bus.ram_addr] = wr_val;
    rd_d    = ram_q[bus.rd_addr];
    mask_d  = bus.clr ? '0 : wr_ok ? mask_q | (8'd1 << bus.ram_addr) : mask_q;
    count_d = bus.clr ? '0 : (wr_ok && count_q != 4'hF) ? count_q + 4'd1 : count_q;
    sum_d   = bus.clr ? '0 : wr_ok ? sum_q + {3'b000, wr_val} : sum_q;
    err_d   = bus.clr ? 1'b0 : err_q | (bus.write_ram & ~valid_q);
  end
  // all state, RAM included, clears asynchronously on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_q   <= '{default: '0};
      stage_q <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ram_q   <= ram_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  assign bus.rd_data     = rd_q;
  assign bus.stage_data  = stage_q;
  assign bus.stage_valid = valid_q;
  assign bus.wr_count    = count_q;
  assign bus.checksum    = sum_q;
  assign bus.done        = &mask_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_rom_ram_datapath.sv
// tb_rom_ram_datapath: three datapaths (offsets 0x00, 0x05, 0xF8) share stimulus; scoreboard vs reference model
module tb_rom_ram_datapath;
  typedef struct packed {
    logic [2:0][7:0]  rd;
    logic [2:0][10:0] sum;
    logic [7:0]       stage;
    logic             sv;
    logic [3:0]       cnt;
    logic             done;
    logic             err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic read_rom = 1'b0, write_ram = 1'b0, clr = 1'b0;
  logic [2:0] rom_addr = '0, ram_addr = '0, rd_addr = '0;
  logic [7:0]  o_rd [3];
  logic [7:0]  o_stage [3];
  logic        o_sv [3];
  logic [3:0]  o_cnt [3];
  logic [10:0] o_sum [3];
  logic        o_done [3];
  logic        o_err [3];
  int checks = 0;
  int failures = 0;
  exp_t q [$];
  always #5 clk = ~clk;
  rom_ram_datapath_if #(.DW(8)) b [3] ();
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign b[g].read_rom  = read_rom;
    assign b[g].write_ram = write_ram;
    assign b[g].rom_addr  = rom_addr;
    assign b[g].ram_addr  = ram_addr;
    assign b[g].clr       = clr;
    assign b[g].rd_addr   = rd_addr;
    assign o_rd[g]    = b[g].rd_data;
    assign o_stage[g] = b[g].stage_data;
    assign o_sv[g]    = b[g].stage_valid;
    assign o_cnt[g]   = b[g].wr_count;
    assign o_sum[g]   = b[g].checksum;
    assign o_done[g]  = b[g].done;
    assign o_err[g]   = b[g].err;
    rom_ram_datapath #(
      .DW(8),
      .ROM_INIT(64'h8070605040302010),
      .OFFSET(g == 0 ? 8'h00 : g == 1 ? 8'h05 : 8'hF8)
    ) u (
      .clk(clk),
      .rst_n(rst_n),
      .bus(b[g])
    );
  end
  // reference model state
  logic [7:0]  m_ram [3][8];
  logic [10:0] m_sum [3];
  logic [7:0]  m_stage;
  logic        m_sv, m_err;
  logic [3:0]  m_cnt;
  bit          m_wr [8];
  function automatic logic [7:0] offs(int k);
    return k == 0 ? 8'h00 : k == 1 ? 8'h05 : 8'hF8;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 8; a++) m_ram[k][a] = 8'h00;
      m_sum[k] = '0;
    end
    for (int a = 0; a < 8; a++) m_wr[a] = 0;
    m_stage = 8'h00;
    m_sv = 1'b0;
    m_err = 1'b0;
    m_cnt = 4'd0;
  endtask
  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction
  // model: compute what each DUT must show after this edge and queue it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      q.delete();
      q.push_back(zero_exp());
    end else begin
      exp_t e;
      logic [7:0] v;
      bit accept, all;
      e = '0;
      for (int k = 0; k < 3; k++) e.rd[k] = m_ram[k][rd_addr];
      accept = write_ram && m_sv;
      if (accept) begin
        for (int k = 0; k < 3; k++) begin
          v = m_stage + offs(k);
          m_ram[k][ram_addr] = v;
          m_sum[k] = m_sum[k] + {3'b000, v};
        end
        m_wr[ram_addr] = 1;
        if (m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
      end
      if (write_ram && !m_sv) m_err = 1'b1;
      if (clr) begin
        for (int a = 0; a < 8; a++) m_wr[a] = 0;
        for (int k = 0; k < 3; k++) m_sum[k] = '0;
        m_cnt = 4'd0;
        m_err = 1'b0;
      end
      if (read_rom) begin
        m_stage = 8'((int'(rom_addr) + 1) * 16);
        m_sv = 1'b1;
      end else if (accept) m_sv = 1'b0;
      all = 1;
      for (int a = 0; a < 8; a++) all = all && m_wr[a];
      for (int k = 0; k < 3; k++) e.sum[k] = m_sum[k];
      e.stage = m_stage;
      e.sv = m_sv;
      e.cnt = m_cnt;
      e.done = all;
      e.err = m_err;
      q.push_back(e);
    end
  end
  task automatic chk(string n, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] t=%0t got=%h expected=%h", n, k, $time, act, exp);
    end
  endtask
  // monitor: pop one expectation per cycle and compare every DUT output
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk("rd_data", k, 32'(o_rd[k]), 32'(e.rd[k]));
        chk("checksum", k, 32'(o_sum[k]), 32'(e.sum[k]));
        chk("stage_data", k, 32'(o_stage[k]), 32'(e.stage));
        chk("stage_valid", k, 32'(o_sv[k]), 32'(e.sv));
        chk("wr_count", k, 32'(o_cnt[k]), 32'(e.cnt));
        chk("done", k, 32'(o_done[k]), 32'(e.done));
        chk("err", k, 32'(o_err[k]), 32'(e.err));
      end
    end
  task automatic step(input logic rr, input logic wr, input logic [2:0] ra,
                      input logic [2:0] wa, input logic c, input logic [2:0] rd);
    @(posedge clk);
    #2;
    read_rom = rr;
    write_ram = wr;
    rom_addr = ra;
    ram_addr = wa;
    clr = c;
    rd_addr = rd;
  endtask
  task automatic readback();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 3'(i));
    step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    readback();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 3'(i), 0, 0, 0);
      step(0, 1, 0, 3'(i), 0, 0);
    end
    readback();
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    readback();
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 2, 0, 2);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 1, 2);
    step(1, 0, 7, 0, 0, 3);
    step(0, 1, 0, 3, 0, 3);
    step(0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 3'($urandom), 0, 0, 0);
      step(0, 1, 0, 3'($urandom), 0, 3'(i));
    end
    step(1, 1, 5, 6, 1, 6);
    step(0, 0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0, 6);
    step(1, 0, 2, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    read_rom = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 1, 0, 4, 0, 4);
    readback();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom), 3'($urandom),
           $urandom_range(0, 19) == 0, 3'($urandom));
    readback();
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_ram_datapath.md
Name: rom_ram_datapath

Overview:
- Datapath stage directly downstream of the ROM-to-RAM control unit.
- Consumes read_rom, write_ram, rom_addr and ram_addr from the control unit.
- Holds an 8-word ROM, a one-word staging register, an offset adder and an 8-word RAM. Also tracks transfer progress, a checksum and a sticky protocol-error flag.
- A registered readback port lets the top level or board I/O inspect RAM contents.

Parameters:
- DW, 8, data word width in bits.
- ROM_INIT, 64'h8070605040302010, packed ROM contents; word i = ROM_INIT[8i+7:8i], so rom[0]=0x10 … rom[7]=0x80.
- OFFSET, 8'h00, constant added (mod 2^DW) to each word before it is written to RAM.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_rom  in  1  from control unit: load rom[rom_addr] into the staging register.
- write_ram  in  1  from control unit: write the staging word + OFFSET to ram[ram_addr].
- rom_addr  in  3  ROM read address.
- ram_addr  in  3  RAM write address.
- clr  in  1  synchronous clear of the status state (mask, checksum, count, err); RAM contents untouched.
- rd_addr  in  3  readback address.
- rd_data  out  DW  ram[rd_addr], registered, 1-cycle latency.
- stage_data  out  DW  current staging-register value.
- stage_valid  out  1  staging register holds an unconsumed word.
- wr_count  out  4  accepted RAM writes since reset/clr; saturates at 15.
- checksum  out  DW+3  sum of all accepted written values, mod 2^(DW+3).
- done  out  1  all 8 RAM addresses written at least once since reset/clr.
- err  out  1  sticky: write_ram arrived while stage_valid=0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - stage_data=0, stage_valid=0, rd_data=0, wr_count=0, checksum=0, done=0, err=0.
  - Internal written_mask=0.
  - All RAM words=0.
  - Reset takes effect immediately, mid-transfer included; nothing pending survives.
- ROM: combinational lookup of ROM_INIT; only the staging register is clocked.
- read_rom=1 at edge: stage_data <= rom[rom_addr], stage_valid <= 1.
- write_ram=1 with stage_valid=1 at edge:
  - ram[ram_addr] <= stage_data + OFFSET, truncated to DW.
  - checksum += that value, truncated to DW+3.
  - wr_count += 1, saturating at 15.
  - written_mask[ram_addr] <= 1.
  - stage_valid <= 0, unless read_rom is also asserted.
- write_ram=1 with stage_valid=0: no RAM write, no counter or checksum change, err <= 1 (sticky).
- read_rom and write_ram in the same cycle:
  - The write uses the old stage_data, from before the edge.
  - The staging register loads the new ROM word.
  - stage_valid ends at 1.
- A second read_rom before a write overwrites stage_data; no error is raised (last read wins).
- done = &written_mask. It is combinational from the mask, so it rises in the cycle after the edge that sets the final bit.
- Repeat writes to the same address count in wr_count and checksum but do not change done.
- Readback: rd_data <= ram[rd_addr] every edge, reading pre-write contents.
  - If the write and the read hit the same address in the same cycle, rd_data shows the old value; the new value appears one cycle later.
- clr=1 at edge (synchronous, reset still dominant):
  - written_mask, wr_count, checksum and err cleared.
  - RAM, stage_data and stage_valid unaffected.
  - A write accepted in the same cycle as clr is discarded from the status but still written to RAM.
- Arithmetic is unsigned throughout. The addresses are exactly 3 bits, so all 8 values are valid and there are no out-of-range cases.

Test Plan:
- Reset and idle: rst_n low for 2 cycles then high, no strobes -> all outputs 0; rd_addr 0..7 returns 0x00.
- Nominal copy, OFFSET=0: for i=0..7, read_rom with rom_addr=i, then write_ram next cycle with ram_addr=i -> ram[i]=0x10*(i+1); wr_count=8; checksum=0x240; done=1 after the last write; err=0.
- Overlap and offset, OFFSET=8'h05: read addr 0, then read_rom(addr 1) together with write_ram(addr 0), then write addr 1 -> ram[0]=0x15, ram[1]=0x25, checksum=0x03A, stage_valid=0 at the end.
- Protocol error: write_ram with no prior read -> RAM unchanged, err=1, wr_count=0; then clr -> err=0.
- Wrap and saturation, OFFSET=8'hF8: copy rom[7] to ram[3] -> ram[3]=0x78 (8-bit wrap). 16 valid write pairs -> wr_count stays at 15.
- Reset mid-operation: rst_n low one cycle after read_rom -> stage_valid=0, RAM cleared. A following write_ram sets err=1 and writes nothing.
